strip_header: RTL and testbench
===============================

Name: strip_header

Overview:
- Downstream counterpart of the header-insertion stage.
- Consumes a 512-bit AXI-stream-like packet stream whose first HDR_BYTES bytes are a header.
- Emits the header on a separate meta channel and the payload re-aligned to byte 0.
- Sits at the receive side of the link, feeding payload consumers that expect header-free, byte-0-aligned data.

Parameters:
- DATA_W, 512: data bus width in bits; multiple of 8.
- KEEP_W, DATA_W/8: byte-enable width.
- HDR_BYTES, 4: header length in bytes; 1..KEEP_W-1.
- META_W, HDR_BYTES*8: meta width in bits.

Ports:
- clock, input, 1: single clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-low reset; 0 = reset asserted.
- io_in_data_valid, input, 1: input beat valid.
- io_in_data_ready, output, 1: input beat accepted when valid & ready.
- io_in_data_bits_data, input, DATA_W: beat data; byte i = bits [8i+7:8i].
- io_in_data_bits_keep, input, KEEP_W: byte enables; contiguous from bit 0.
- io_in_data_bits_last, input, 1: final beat of packet.
- io_out_meta_valid, output, 1: header available.
- io_out_meta_ready, input, 1: header consumed.
- io_out_meta_bits, output, META_W: bytes 0..HDR_BYTES-1 of the first beat (data[META_W-1:0]).
- io_out_data_valid, output, 1.
- io_out_data_ready, input, 1.
- io_out_data_bits_data, output, DATA_W.
- io_out_data_bits_keep, output, KEEP_W.
- io_out_data_bits_last, output, 1.

Behaviour:
- Reset: all valids 0, io_in_data_ready 0, data/keep/last/meta registers 0, state HEAD.
- Outputs are registered: one-entry output slot per channel.
- A slot may load when it is empty or being drained in the same cycle (valid & ready).
- A held output is stable until accepted (no valid drop, no bits change).
- Residual register RES holds bytes HDR_BYTES..KEEP_W-1 of the previous input beat, stored at bytes 0..KEEP_W-HDR_BYTES-1, with matching keep.
- State HEAD:
  - io_in_data_ready = meta slot loadable AND data slot loadable.
  - On accept: meta slot <- data[META_W-1:0]; RES <- upper bytes.
  - If !last: goto BODY.
  - If last and keep[KEEP_W-1:HDR_BYTES]!=0: goto FLUSH.
  - If last and upper keep is 0 (header-only packet): load data slot with data 0, keep 0, last 1; stay HEAD. Every meta is therefore paired with exactly one output packet.
- State BODY:
  - io_in_data_ready = data slot loadable.
  - On accept, output beat data = {in.data[HDR_BYTES*8-1:0], RES.data}; keep = {in.keep[HDR_BYTES-1:0], RES.keep}.
  - RES <- upper bytes of the input beat.
  - If in.last and in.keep[KEEP_W-1:HDR_BYTES]==0: output last=1, goto HEAD.
  - Else if in.last: output last=0, goto FLUSH.
  - Else: stay BODY.
- State FLUSH:
  - io_in_data_ready = 0.
  - When data slot loadable: emit {0, RES.data}, keep {0, RES.keep}, last=1; goto HEAD.
- Latency: one cycle from input acceptance to the corresponding output valid. A FLUSH beat costs one extra cycle with the input stalled.
- Meta backpressure blocks only the next packet's first beat, never the current packet's body.
- Simultaneous drain and load of a slot in one cycle is allowed; full throughput is 1 beat/cycle in BODY.
- Reset asserted mid-packet: state returns to HEAD and partial data is discarded. Upstream is responsible for restarting on a packet boundary.

Optional Feature:
- Macro STRIP_HEADER_LEN_CHECK_EN.
- When defined:
  - Adds output port io_len_err (1 bit).
  - A 16-bit counter accumulates popcount of output keep per packet.
  - On the output beat with last=1 accepted, io_len_err pulses high for one cycle if the count != meta[15:0].
  - The counter clears on that beat and on reset.
- When undefined: no port, no counter, identical datapath timing.

Decomposition:
- Shared package strip_header_pkg:
  - state enum {HEAD, BODY, FLUSH}.
  - DATA_W/KEEP_W/HDR_BYTES defaults.
  - Beat struct {last, data, keep}; shared with the header-insertion stage.
- Natural sub-module: reg_slice_1 (one-entry valid/ready output register), instantiated for the meta and data channels.

Test Plan:
- Two-beat packet: beat0 data[31:0]=32'h1111, data[63:32]=32'h01, keep all F, last 0; beat1 data 0, keep all F, last 1.
  - Expect meta 32'h1111.
  - out beat0 data[31:0]=32'h01, keep 64'hFFFFFFFFFFFFFFFF, last 0.
  - out beat1 keep 64'h0FFFFFFFFFFFFFFF, last 1 (FLUSH).
- Last beat with keep 64'h000000000000000F:
  - Expect no FLUSH; final output keep = {4'hF, prior RES keep}, last 1, in the same cycle as input acceptance +1.
- Header-only packet: one beat keep 64'hF, last 1.
  - Expect meta emitted plus one data beat with keep 0, last 1.
- Back-to-back packets with io_out_meta_ready held 0:
  - Second packet's first beat stalls (io_in_data_ready 0) until meta is accepted.
  - First packet's body and flush complete normally.
- Random io_out_data_ready toggling over 100 packets:
  - Output payload bytes equal input minus header; no beat lost or duplicated; bits stable while valid & !ready.
- With STRIP_HEADER_LEN_CHECK_EN:
  - meta[15:0]=16'd120 and 120 payload bytes -> io_len_err stays 0.
  - meta[15:0]=16'd100 -> one-cycle io_len_err pulse on the last beat.

Source files
------------

// File: rtl/strip_header_pkg.sv
// Shared types for the header insertion/strip pair: FSM states, default widths
// and the stream beat record.
package strip_header_pkg;

    localparam int DEF_DATA_W    = 512;
    localparam int DEF_KEEP_W    = DEF_DATA_W / 8;
    localparam int DEF_HDR_BYTES = 4;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        FLUSH
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_KEEP_W-1:0] keep;
    } beat_t;

endpackage

// File: rtl/reg_slice_1.sv
// One-entry valid/ready output register. The owner only pulses load when
// loadable is high; held contents never change until accepted.
module reg_slice_1 #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_bits,
    output logic         loadable,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] bits
);

    assign loadable = !valid || ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            bits  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            bits  <= load_bits;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/strip_header.sv
// Strips a HDR_BYTES header off each packet, emits it on the meta channel and
// re-aligns the payload to byte 0. Optional length check: STRIP_HEADER_LEN_CHECK_EN.
module strip_header
    import strip_header_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int HDR_BYTES = DEF_HDR_BYTES,
    parameter int META_W    = HDR_BYTES * 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_data_valid,
    output logic              io_in_data_ready,
    input  logic [DATA_W-1:0] io_in_data_bits_data,
    input  logic [KEEP_W-1:0] io_in_data_bits_keep,
    input  logic              io_in_data_bits_last,
    output logic              io_out_meta_valid,
    input  logic              io_out_meta_ready,
    output logic [META_W-1:0] io_out_meta_bits,
    output logic              io_out_data_valid,
    input  logic              io_out_data_ready,
    output logic [DATA_W-1:0] io_out_data_bits_data,
    output logic [KEEP_W-1:0] io_out_data_bits_keep,
    output logic              io_out_data_bits_last
`ifdef STRIP_HEADER_LEN_CHECK_EN
    ,
    output logic              io_len_err
`endif
);

    localparam int RES_BYTES = KEEP_W - HDR_BYTES;
    localparam int SLOT_W    = DATA_W + KEEP_W + 1;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] res_data;
    logic [KEEP_W-1:0] res_keep;
    logic              res_load;
    logic              accept, upper_nz;

    logic              meta_load, meta_loadable;
    logic              data_load, data_loadable;
    logic [DATA_W-1:0] d_data;
    logic [KEEP_W-1:0] d_keep;
    logic              d_last;

    assign accept   = io_in_data_valid && io_in_data_ready;
    assign upper_nz = |io_in_data_bits_keep[KEEP_W-1:HDR_BYTES];

    always_comb begin
        state_nxt        = state;
        io_in_data_ready = 1'b0;
        meta_load        = 1'b0;
        data_load        = 1'b0;
        res_load         = 1'b0;
        d_data           = '0;
        d_keep           = '0;
        d_last           = 1'b0;
        case (state)
            HEAD: begin
                // Both slots must have room: a header-only packet loads both at once.
                io_in_data_ready = reset && meta_loadable && data_loadable;
                if (accept) begin
                    meta_load = 1'b1;
                    res_load  = 1'b1;
                    if (!io_in_data_bits_last) begin
                        state_nxt = BODY;
                    end else if (upper_nz) begin
                        state_nxt = FLUSH;
                    end else begin
                        data_load = 1'b1;
                        d_last    = 1'b1;
                    end
                end
            end
            BODY: begin
                io_in_data_ready = reset && data_loadable;
                if (accept) begin
                    data_load = 1'b1;
                    res_load  = 1'b1;
                    d_data    = res_data | (io_in_data_bits_data << (RES_BYTES * 8));
                    d_keep    = res_keep | (io_in_data_bits_keep << RES_BYTES);
                    if (io_in_data_bits_last && !upper_nz) begin
                        d_last    = 1'b1;
                        state_nxt = HEAD;
                    end else if (io_in_data_bits_last) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (data_loadable) begin
                    data_load = 1'b1;
                    d_data    = res_data;
                    d_keep    = res_keep;
                    d_last    = 1'b1;
                    state_nxt = HEAD;
                end
            end
            default: state_nxt = HEAD;
        endcase
    end

    // Residual keeps the beat's tail bytes shifted down to byte 0, upper bytes zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= HEAD;
            res_data <= '0;
            res_keep <= '0;
        end else begin
            state <= state_nxt;
            if (res_load) begin
                res_data <= io_in_data_bits_data >> (HDR_BYTES * 8);
                res_keep <= io_in_data_bits_keep >> HDR_BYTES;
            end
        end
    end

    reg_slice_1 #(.W(META_W)) u_meta_slot (
        .clock     (clock),
        .reset     (reset),
        .load      (meta_load),
        .load_bits (io_in_data_bits_data[META_W-1:0]),
        .loadable  (meta_loadable),
        .valid     (io_out_meta_valid),
        .ready     (io_out_meta_ready),
        .bits      (io_out_meta_bits)
    );

    reg_slice_1 #(.W(SLOT_W)) u_data_slot (
        .clock     (clock),
        .reset     (reset),
        .load      (data_load),
        .load_bits ({d_last, d_keep, d_data}),
        .loadable  (data_loadable),
        .valid     (io_out_data_valid),
        .ready     (io_out_data_ready),
        .bits      ({io_out_data_bits_last, io_out_data_bits_keep, io_out_data_bits_data})
    );

`ifdef STRIP_HEADER_LEN_CHECK_EN
    logic [15:0] len_cnt, len_sum, keep_cnt, hdr_len;
    logic        out_fire;

    assign out_fire = io_out_data_valid && io_out_data_ready;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KEEP_W; i++) keep_cnt = keep_cnt + 16'(io_out_data_bits_keep[i]);
    end

    assign len_sum = len_cnt + keep_cnt;

    // hdr_len can only be overwritten once the previous packet's last beat drains,
    // so it still belongs to the packet being counted when its last beat leaves.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_cnt <= '0;
            hdr_len <= '0;
        end else begin
            if (meta_load) hdr_len <= 16'(io_in_data_bits_data[META_W-1:0]);
            if (out_fire)  len_cnt <= io_out_data_bits_last ? 16'd0 : len_sum;
        end
    end

    assign io_len_err = out_fire && io_out_data_bits_last && (len_sum != hdr_len);
`endif

endmodule

// File: tb/tb_strip_header.sv
// Self-checking bench for strip_header: byte-level packet model feeding a
// scoreboard, a table of packet sizes, and hand-written corner sequences.
module tb_strip_header;
    import strip_header_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int KW = DEF_KEEP_W;
    localparam int HB = DEF_HDR_BYTES;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [KW-1:0] in_keep = '0;
    logic          meta_valid, meta_ready = 1'b1;
    logic [31:0]   meta_bits;
    logic          out_valid, out_ready = 1'b1, out_last;
    logic [DW-1:0] out_data;
    logic [KW-1:0] out_keep;
`ifdef STRIP_HEADER_LEN_CHECK_EN
    logic          len_err;
`endif

    always #5 clock = ~clock;

    strip_header dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_in_data_valid      (in_valid),
        .io_in_data_ready      (in_ready),
        .io_in_data_bits_data  (in_data),
        .io_in_data_bits_keep  (in_keep),
        .io_in_data_bits_last  (in_last),
        .io_out_meta_valid     (meta_valid),
        .io_out_meta_ready     (meta_ready),
        .io_out_meta_bits      (meta_bits),
        .io_out_data_valid     (out_valid),
        .io_out_data_ready     (out_ready),
        .io_out_data_bits_data (out_data),
        .io_out_data_bits_keep (out_keep),
        .io_out_data_bits_last (out_last)
`ifdef STRIP_HEADER_LEN_CHECK_EN
        ,
        .io_len_err            (len_err)
`endif
    );

    int          tests = 0, fails = 0;
    beat_t       exp_q[$];
    logic [31:0] meta_q[$];
    logic [7:0]  pkt[$];
    bit          mon_en = 0, rnd_mode = 0, meta_hold = 0;
    int          beats_out = 0, len_errs = 0;
    logic [KW-1:0] last_keep_seen = '0;
    logic [31:0]   last_meta_seen = '0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    // Model: payload is the packet minus the header, repacked into KW-byte beats.
    task automatic send_pkt();
        int    n, nb, to, j;
        beat_t b;
        n = pkt.size();
        meta_q.push_back({pkt[3], pkt[2], pkt[1], pkt[0]});
        b = '0;
        if (n <= HB) begin
            b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int i = HB; i < n; i++) begin
                j = (i - HB) % KW;
                b.data[8*j +: 8] = pkt[i];
                b.keep[j] = 1'b1;
                if (j == KW - 1 || i == n - 1) begin
                    b.last = (i == n - 1);
                    exp_q.push_back(b);
                    b = '0;
                end
            end
        end
        nb = (n + KW - 1) / KW;
        for (int k = 0; k < nb; k++) begin
            @(posedge clock); #1;
            in_valid = 1'b1;
            in_data  = '0;
            in_keep  = '0;
            for (int m = 0; m < KW; m++) begin
                if (k * KW + m < n) begin
                    in_data[8*m +: 8] = pkt[k*KW+m];
                    in_keep[m] = 1'b1;
                end
            end
            in_last = (k == nb - 1);
            to = 0;
            do begin
                @(negedge clock);
                to++;
            end while (!in_ready && to < 400);
            if (!in_ready) begin
                timeout_fail("in_accept");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rand_pkt(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    endtask

    task automatic wait_drain();
        int to = 0;
        while ((exp_q.size() != 0 || meta_q.size() != 0) && to < 2000) begin
            @(negedge clock);
            to++;
        end
        if (to >= 2000) timeout_fail("drain");
    endtask

    // Consumer side: ready patterns change just after the rising edge.
    always begin
        @(posedge clock); #1;
        out_ready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        meta_ready = meta_hold ? 1'b0 : (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    beat_t       e, prev_d;
    logic [31:0] em, prev_m;
    bit          d_stall = 0, m_stall = 0;

    always @(negedge clock) begin
        if (mon_en) begin
            if (d_stall) begin
                chk("data_hold_valid", out_valid, 1);
                chk("data_hold_data", out_data, prev_d.data);
                chk("data_hold_keep", out_keep, prev_d.keep);
                chk("data_hold_last", out_last, prev_d.last);
            end
            if (out_valid && out_ready) begin
                beats_out++;
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_data_beat");
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_keep", out_keep, e.keep);
                    chk("out_last", out_last, e.last);
                end
                if (out_last) last_keep_seen = out_keep;
            end
            d_stall     = out_valid && !out_ready;
            prev_d.data = out_data;
            prev_d.keep = out_keep;
            prev_d.last = out_last;

            if (m_stall) begin
                chk("meta_hold_valid", meta_valid, 1);
                chk("meta_hold_bits", meta_bits, prev_m);
            end
            if (meta_valid && meta_ready) begin
                if (meta_q.size() == 0) begin
                    timeout_fail("unexpected_meta");
                end else begin
                    em = meta_q.pop_front();
                    chk("meta_bits", meta_bits, em);
                end
                last_meta_seen = meta_bits;
            end
            m_stall = meta_valid && !meta_ready;
            prev_m  = meta_bits;
`ifdef STRIP_HEADER_LEN_CHECK_EN
            if (len_err) len_errs++;
`endif
        end
    end

    typedef struct {
        int nbytes;
        int exp_beats;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int b0;
        tbl[0] = '{68, 1};
        tbl[1] = '{4, 1};
        tbl[2] = '{128, 2};
        tbl[3] = '{132, 2};
        tbl[4] = '{64, 1};
        tbl[5] = '{65, 1};
        tbl[6] = '{5, 1};
        tbl[7] = '{200, 4};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_data_valid", out_valid, 0);
        chk("rst_meta_valid", meta_valid, 0);
        chk("rst_meta_bits", meta_bits, 0);
        chk("rst_out_keep", out_keep, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clock); #2;
        reset  = 1'b1;
        mon_en = 1;
        @(negedge clock);
        chk("idle_in_ready", in_ready, 1);

        // Two-beat packet with full last beat: needs a FLUSH beat
        pkt.delete();
        for (int i = 0; i < 128; i++) pkt.push_back(8'h00);
        pkt[0] = 8'h11;
        pkt[1] = 8'h11;
        pkt[4] = 8'h01;
        send_pkt();
        wait_drain();
        chk("t1_meta", last_meta_seen, 32'h1111);
        chk("t1_flush_keep", last_keep_seen, 64'h0FFFFFFFFFFFFFFF);

        // Last beat carries only 4 bytes: final beat one cycle after acceptance
        rand_pkt(68);
        send_pkt();
        @(negedge clock);
        chk("lat_valid", out_valid, 1);
        chk("lat_last", out_last, 1);
        chk("lat_keep", out_keep, {KW{1'b1}});
        wait_drain();

        // Header-only packet
        rand_pkt(4);
        send_pkt();
        wait_drain();
        chk("hdr_only_keep", last_keep_seen, 0);
        chk("hdr_only_meta", last_meta_seen, {pkt[3], pkt[2], pkt[1], pkt[0]});

        // Table of sizes with known output beat counts
        for (int i = 0; i < 8; i++) begin
            rand_pkt(tbl[i].nbytes);
            b0 = beats_out;
            send_pkt();
            wait_drain();
            chk("tbl_beats", beats_out - b0, tbl[i].exp_beats);
        end

        // Meta held: body and flush of A complete, B's first beat stalls
        meta_hold = 1;
        rand_pkt(150);
        send_pkt();
        rand_pkt(70);
        fork
            send_pkt();
            begin
                repeat (6) begin
                    @(negedge clock);
                    chk("mh_stall_ready", in_ready, 0);
                end
                meta_hold = 0;
            end
        join
        wait_drain();

        // Random downstream backpressure over 100 packets
        rnd_mode = 1;
        for (int p = 0; p < 100; p++) begin
            rand_pkt($urandom_range(4, 300));
            send_pkt();
        end
        wait_drain();
        rnd_mode = 0;

`ifdef STRIP_HEADER_LEN_CHECK_EN
        repeat (3) @(negedge clock);
        len_errs = 0;
        rand_pkt(124);
        pkt[0] = 8'd120;
        pkt[1] = 8'd0;
        send_pkt();
        wait_drain();
        chk("len_ok", len_errs, 0);
        rand_pkt(124);
        pkt[0] = 8'd100;
        pkt[1] = 8'd0;
        send_pkt();
        wait_drain();
        chk("len_err_pulse", len_errs, 1);
`endif

        repeat (3) @(negedge clock);
        chk("sb_data_empty", exp_q.size(), 0);
        chk("sb_meta_empty", meta_q.size(), 0);
        chk("final_out_valid", out_valid, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
